// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Hazard controller for the in-order pipeline, sitting beside ID.
// It combines load-use / multi-cycle interlocking (a per-register
// countdown scoreboard) with forwarding-select generation (a shadow copy
// of the DEPTH post-ID stages).
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_id_valid          ID holds a real instruction
//   i_id_rs1/rs2        ID source register indices
//   i_id_use1/use2      the corresponding source is actually read
//   i_id_rd             ID destination index
//   i_id_regwrite       ID instruction writes i_id_rd
//   i_id_lat            bubbles a dependent needs (0 ALU, 1 load, N multi-cycle)
//   i_flush             taken branch in ID, ID instruction is discarded
//   i_ex_hold           multi-cycle unit freezes EX and everything behind it
//   o_stall             hold PC and IF_ID
//   o_ex_bubble         load a NOP into ID/EX this edge
//   o_issue             ID instruction advances to EX this edge
//   o_fwd_a/o_fwd_b     EX operand source: 0 = regfile, k = result in slot k+1
//   o_busy              bit r set while register r has a pending countdown
module pipe_hazard_ctrl #(
  parameter int NREG   = 32,
  parameter int RW     = $clog2(NREG),
  parameter int DEPTH  = 3,
  parameter int MAXLAT = 7,
  parameter int LW     = $clog2(MAXLAT + 1),
  parameter int FW     = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  input  logic [RW-1:0]   i_id_rs1,
  input  logic [RW-1:0]   i_id_rs2,
  input  logic            i_id_use1,
  input  logic            i_id_use2,
  input  logic [RW-1:0]   i_id_rd,
  input  logic            i_id_regwrite,
  input  logic [LW-1:0]   i_id_lat,
  input  logic            i_flush,
  input  logic            i_ex_hold,
  output logic            o_stall,
  output logic            o_ex_bubble,
  output logic            o_issue,
  output logic [FW-1:0]   o_fwd_a,
  output logic [FW-1:0]   o_fwd_b,
  output logic [NREG-1:0] o_busy
);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } slot_t;

  logic [LW-1:0] r_cnt [NREG];
  slot_t         r_slot [1:DEPTH];

  logic          w_hazard;
  logic          w_stall;
  logic          w_issue;
  logic          w_sb_write;
  logic [LW-1:0] w_lat_clamped;
  logic [FW-1:0] w_fwd_a;
  logic [FW-1:0] w_fwd_b;
  logic [NREG-1:0] w_busy;
  slot_t         w_id_slot;

  // Register 0 is never tracked, so a read of x0 can never interlock.
  always_comb begin
    w_hazard = i_id_valid &&
               ((i_id_use1 && (i_id_rs1 != '0) && (r_cnt[i_id_rs1] != '0)) ||
                (i_id_use2 && (i_id_rs2 != '0) && (r_cnt[i_id_rs2] != '0)));
  end

  // A flush discards the ID instruction, so its hazard is irrelevant;
  // ex_hold freezes the front end regardless.
  always_comb begin
    w_stall    = (w_hazard && !i_flush) || i_ex_hold;
    w_issue    = i_id_valid && !i_flush && !w_stall;
    w_sb_write = w_issue && i_id_regwrite && (i_id_rd != '0);
  end

  // Oversized latencies saturate at MAXLAT instead of wrapping.
  always_comb begin
    if (i_id_lat > LW'(MAXLAT)) begin
      w_lat_clamped = LW'(MAXLAT);
    end else begin
      w_lat_clamped = i_id_lat;
    end
  end

  always_comb begin
    w_id_slot       = '0;
    w_id_slot.valid = 1'b1;
    w_id_slot.wen   = i_id_regwrite;
    w_id_slot.rd    = i_id_rd;
    w_id_slot.rs1   = i_id_rs1;
    w_id_slot.rs2   = i_id_rs2;
  end

  // Countdown scoreboard. The new-producer write comes after the
  // decrement loop so it overrides the decrement on the same register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else if (!i_ex_hold) begin
      for (int r = 0; r < NREG; r++) begin
        if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - LW'(1);
        end
      end
      if (w_sb_write) begin
        r_cnt[i_id_rd] <= w_lat_clamped;
      end
    end
  end

  // Shadow of the post-ID stages; a non-issuing cycle shifts in a bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_slot[k] <= '0;
      end
    end else if (!i_ex_hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_slot[k] <= r_slot[k-1];
      end
      r_slot[1] <= w_issue ? w_id_slot : '0;
    end
  end

  // Scan from the oldest slot toward EX so the youngest matching
  // producer is the last assignment and wins. rd != 0 also makes a
  // source index of 0 always resolve to the register file.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (r_slot[k+1].valid && r_slot[k+1].wen && (r_slot[k+1].rd != '0)) begin
        if (r_slot[k+1].rd == r_slot[1].rs1) begin
          w_fwd_a = FW'(k);
        end
        if (r_slot[k+1].rd == r_slot[1].rs2) begin
          w_fwd_b = FW'(k);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  assign o_stall     = w_stall;
  assign o_issue     = w_issue;
  assign o_ex_bubble = !w_issue && !i_ex_hold;
  assign o_fwd_a     = w_fwd_a;
  assign o_fwd_b     = w_fwd_b;
  assign o_busy      = w_busy;

endmodule
